// File: rtl/soc_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : soc_sram_bridge_if
// Description : Bus bundle for soc_sram_bridge. Carries the request channel
//               (req_*), the response channel (resp_*) and the command /
//               read-data path to the SRAM controller (sram_*).
//   master    : environment side (drives requests, resp_ready, SRAM returns)
//   slave     : bridge side (drives req_ready, responses, SRAM commands)
// Revision    : 1.0 - initial release
// ============================================================================
interface soc_sram_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_write;
    logic [31:0] resp_rdata;

    logic        sram_ena;
    logic [3:0]  sram_wea;
    logic [19:0] sram_addra;
    logic [31:0] sram_dina;
    logic [31:0] sram_douta;
    logic        sram_readya;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
               sram_douta, sram_readya,
        input  req_ready, resp_valid, resp_write, resp_rdata,
               sram_ena, sram_wea, sram_addra, sram_dina
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
               sram_douta, sram_readya,
        output req_ready, resp_valid, resp_write, resp_rdata,
               sram_ena, sram_wea, sram_addra, sram_dina
    );
endinterface
`default_nettype wire

// File: rtl/soc_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : soc_sram_bridge
// Description : Bridges a valid/ready request/response bus onto a fixed
//               4-cycle-latency SRAM controller. Requests queue in a 2-entry
//               FIFO, issue when the controller is ready and a response slot
//               is reserved, travel a 4-stage tracking pipeline, and land in
//               an in-order response FIFO of RESP_DEPTH entries.
// Ports       : clk, reset (async, active high)
//               bus (soc_sram_bridge_if.slave): req_*, resp_*, sram_*
// Parameters  : RESP_DEPTH - response FIFO depth and outstanding limit
//                            (power of two, 2..16)
// Revision    : 1.0 - initial release
// ============================================================================
module soc_sram_bridge #(
    parameter int RESP_DEPTH = 4
) (
    input  wire              clk,
    input  wire              reset,
    soc_sram_bridge_if.slave bus
);
    localparam int c_PTR_W  = $clog2(RESP_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_STAGES = 4;

    // Request FIFO (2 entries)
    logic [3:0]  r_rq_we    [2];
    logic [19:0] r_rq_addr  [2];
    logic [31:0] r_rq_wdata [2];
    logic        r_rq_wptr;
    logic        r_rq_rptr;
    logic [1:0]  r_rq_count;

    // Tracking pipeline and outstanding counter
    logic [c_STAGES-1:0] r_trk_v;
    logic [c_STAGES-1:0] r_trk_w;
    logic [2:0]          r_in_flight;

    // Response FIFO
    logic               r_rs_w    [RESP_DEPTH];
    logic [31:0]        r_rs_data [RESP_DEPTH];
    logic [c_PTR_W-1:0] r_rs_wptr;
    logic [c_PTR_W-1:0] r_rs_rptr;
    logic [c_CNT_W-1:0] r_rs_count;

    logic       w_rq_empty;
    logic       w_req_ready;
    logic       w_rq_push;
    logic [5:0] w_used;
    logic       w_credit;
    logic       w_issue;
    logic       w_rs_push;
    logic       w_rs_pop;
    logic       w_resp_valid;
    logic       w_addr_unused;

    // Only the word address [21:2] reaches the SRAM.
    assign w_addr_unused = ^{bus.req_addr[31:22], bus.req_addr[1:0]};

    assign w_rq_empty  = (r_rq_count == 2'd0);
    // Held low during reset even though the FIFO count is already zero.
    assign w_req_ready = ~reset & (r_rq_count < 2'd2);
    assign w_rq_push   = bus.req_valid & w_req_ready;

    // A response slot is reserved at issue time, so the response FIFO can
    // never overflow: in-flight plus buffered responses stay <= RESP_DEPTH.
    assign w_used   = 6'(r_in_flight) + 6'(r_rs_count);
    assign w_credit = (w_used < 6'(RESP_DEPTH));
    assign w_issue  = ~w_rq_empty & bus.sram_readya & w_credit;

    assign w_rs_push    = r_trk_v[c_STAGES-1];
    assign w_resp_valid = (r_rs_count != '0);
    assign w_rs_pop     = w_resp_valid & bus.resp_ready;

    assign bus.req_ready  = w_req_ready;
    assign bus.sram_ena   = w_issue;
    assign bus.sram_wea   = w_rq_empty ? 4'd0  : r_rq_we[r_rq_rptr];
    assign bus.sram_addra = w_rq_empty ? 20'd0 : r_rq_addr[r_rq_rptr];
    assign bus.sram_dina  = w_rq_empty ? 32'd0 : r_rq_wdata[r_rq_rptr];

    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_write = w_resp_valid & r_rs_w[r_rs_rptr];
    assign bus.resp_rdata = w_resp_valid ? r_rs_data[r_rs_rptr] : 32'd0;

    // Control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rq_wptr   <= 1'b0;
            r_rq_rptr   <= 1'b0;
            r_rq_count  <= 2'd0;
            r_trk_v     <= '0;
            r_trk_w     <= '0;
            r_in_flight <= 3'd0;
            r_rs_wptr   <= '0;
            r_rs_rptr   <= '0;
            r_rs_count  <= '0;
        end else begin
            if (w_rq_push) r_rq_wptr <= ~r_rq_wptr;
            if (w_issue)   r_rq_rptr <= ~r_rq_rptr;
            case ({w_rq_push, w_issue})
                2'b10:   r_rq_count <= r_rq_count + 2'd1;
                2'b01:   r_rq_count <= r_rq_count - 2'd1;
                default: r_rq_count <= r_rq_count;
            endcase

            r_trk_v <= {r_trk_v[c_STAGES-2:0], w_issue};
            r_trk_w <= {r_trk_w[c_STAGES-2:0],
                        w_issue & (r_rq_we[r_rq_rptr] != 4'd0)};

            case ({w_issue, w_rs_push})
                2'b10:   r_in_flight <= r_in_flight + 3'd1;
                2'b01:   r_in_flight <= r_in_flight - 3'd1;
                default: r_in_flight <= r_in_flight;
            endcase

            if (w_rs_push) r_rs_wptr <= r_rs_wptr + c_PTR_W'(1);
            if (w_rs_pop)  r_rs_rptr <= r_rs_rptr + c_PTR_W'(1);
            case ({w_rs_push, w_rs_pop})
                2'b10:   r_rs_count <= r_rs_count + c_CNT_W'(1);
                2'b01:   r_rs_count <= r_rs_count - c_CNT_W'(1);
                default: r_rs_count <= r_rs_count;
            endcase
        end
    end

    // Storage arrays carry no reset; validity comes from the counters.
    always_ff @(posedge clk) begin
        if (w_rq_push) begin
            r_rq_we[r_rq_wptr]    <= bus.req_we;
            r_rq_addr[r_rq_wptr]  <= bus.req_addr[21:2];
            r_rq_wdata[r_rq_wptr] <= bus.req_wdata;
        end
        if (w_rs_push) begin
            r_rs_w[r_rs_wptr]    <= r_trk_w[c_STAGES-1];
            r_rs_data[r_rs_wptr] <= r_trk_w[c_STAGES-1] ? 32'd0 : bus.sram_douta;
        end
    end

    a_no_resp_overflow : assert property (@(posedge clk) disable iff (reset)
        !(w_rs_push && !w_rs_pop && (r_rs_count == c_CNT_W'(RESP_DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_soc_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_sram_bridge
// Description : Self-checking bench for soc_sram_bridge. A queue-level model
//               predicts every output each cycle; directed scenarios add
//               literal expectations (single read, byte write, streaming,
//               backpressure, reset mid-operation). A small SRAM controller
//               model returns read data 4 cycles after each command and
//               drops readya for 2 cycles after each command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_sram_bridge;
    localparam int c_DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    soc_sram_bridge_if bus ();

    soc_sram_bridge #(.RESP_DEPTH(c_DEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int ena_cnt  = 0;
    int pop_cnt  = 0;
    int prev_ena = -1;
    int bad_gaps = 0;
    bit gap_track   = 1'b0;
    bit rr_low_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [3:0] we; logic [19:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { logic w; int due; } fly_t;
    typedef struct { logic w; logic [31:0] data; } rsp_t;

    req_t pend_q[$];
    fly_t fly_q[$];
    rsp_t rsp_q[$];

    initial begin
        forever begin
            logic exp_rr, exp_iss, exp_rv;
            req_t h;
            rsp_t r;
            fly_t f;
            req_t nq;
            @(negedge clk);
            if (reset) begin
                chk("rst_req_ready",  bus.req_ready,  32'd0);
                chk("rst_resp_valid", bus.resp_valid, 32'd0);
                chk("rst_resp_write", bus.resp_write, 32'd0);
                chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
                chk("rst_sram_ena",   bus.sram_ena,   32'd0);
                chk("rst_sram_wea",   bus.sram_wea,   32'd0);
                chk("rst_sram_addra", bus.sram_addra, 32'd0);
                chk("rst_sram_dina",  bus.sram_dina,  32'd0);
                pend_q.delete();
                fly_q.delete();
                rsp_q.delete();
            end else begin
                exp_rr  = (pend_q.size() < 2);
                exp_iss = (pend_q.size() > 0) && bus.sram_readya &&
                          ((fly_q.size() + rsp_q.size()) < c_DEPTH);
                exp_rv  = (rsp_q.size() > 0);
                h = '{we: 4'd0, addr: 20'd0, wdata: 32'd0};
                if (pend_q.size() > 0) h = pend_q[0];
                r = '{w: 1'b0, data: 32'd0};
                if (exp_rv) r = rsp_q[0];

                chk("cmp_req_ready",  bus.req_ready,  exp_rr);
                chk("cmp_sram_ena",   bus.sram_ena,   exp_iss);
                chk("cmp_sram_wea",   bus.sram_wea,   h.we);
                chk("cmp_sram_addra", bus.sram_addra, h.addr);
                chk("cmp_sram_dina",  bus.sram_dina,  h.wdata);
                chk("cmp_resp_valid", bus.resp_valid, exp_rv);
                chk("cmp_resp_write", bus.resp_write, r.w);
                chk("cmp_resp_rdata", bus.resp_rdata, r.data);

                if (bus.sram_ena) begin
                    ena_cnt++;
                    if (gap_track && prev_ena >= 0 && (cyc - prev_ena) != 3) bad_gaps++;
                    prev_ena = cyc;
                end
                if (bus.resp_valid && bus.resp_ready) pop_cnt++;

                if (exp_rv && bus.resp_ready) void'(rsp_q.pop_front());
                if (fly_q.size() > 0 && fly_q[0].due == cyc) begin
                    r.w    = fly_q[0].w;
                    r.data = fly_q[0].w ? 32'd0 : bus.sram_douta;
                    rsp_q.push_back(r);
                    void'(fly_q.pop_front());
                end
                if (exp_iss) begin
                    f.w   = (h.we != 4'd0);
                    f.due = cyc + 4;
                    fly_q.push_back(f);
                    void'(pend_q.pop_front());
                end
                if (bus.req_valid && exp_rr) begin
                    nq.we    = bus.req_we;
                    nq.addr  = bus.req_addr[21:2];
                    nq.wdata = bus.req_wdata;
                    pend_q.push_back(nq);
                end
            end
        end
    end

    // ---------------- SRAM controller model ----------------
    logic [31:0] mem   [16];
    logic [31:0] dpipe [4];
    logic        dval  [4];
    int          busy;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE0000 + 32'(i);
        mem[4] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin dval[i] = 1'b0; dpipe[i] = 32'd0; end
        busy = 0;
        bus.sram_readya = 1'b1;
        bus.sram_douta  = 32'hBAD00000;
        forever begin
            logic        e;
            logic [3:0]  we;
            logic [19:0] a;
            logic [31:0] d;
            @(negedge clk);
            e  = bus.sram_ena;
            we = bus.sram_wea;
            a  = bus.sram_addra;
            d  = bus.sram_dina;
            @(posedge clk);
            #1;
            if (reset) begin
                busy = 0;
                for (int i = 0; i < 4; i++) dval[i] = 1'b0;
            end else begin
                for (int i = 3; i > 0; i--) begin
                    dpipe[i] = dpipe[i-1];
                    dval[i]  = dval[i-1];
                end
                dval[0]  = e && (we == 4'd0);
                dpipe[0] = mem[a[3:0]];
                if (e && we != 4'd0)
                    for (int b = 0; b < 4; b++)
                        if (we[b]) mem[a[3:0]][8*b +: 8] = d[8*b +: 8];
                if (e) busy = 2;
                else if (busy > 0) busy--;
            end
            bus.sram_readya = (busy == 0);
            bus.sram_douta  = dval[3] ? dpipe[3] : (32'hBAD00000 | 32'(cyc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        bus.req_valid = 1'b0;
        bus.req_we    = 4'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
    endtask

    // Offers n reads at consecutive words from base, holding req_valid.
    task automatic offer_reads(input int n, input logic [31:0] base, input int cycles,
                               output int accepted);
        accepted      = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 4'd0;
        bus.req_addr  = base;
        bus.req_wdata = 32'd0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) accepted++;
            if (!bus.req_ready) rr_low_seen = 1'b1;
            step();
            if (accepted >= n) bus.req_valid = 1'b0;
            else bus.req_addr = base + 32'(accepted * 4);
        end
        idle_req();
    endtask

    initial begin
        int acc, e0, p0, e1, p1;
        bit ok;
        idle_req();
        bus.resp_ready = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("lit_req_ready_in_reset", bus.req_ready, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("lit_req_ready_after_reset", bus.req_ready, 32'd1);
        chk("lit_resp_valid_after_reset", bus.resp_valid, 32'd0);
        step();
        bus.resp_ready = 1'b1;

        // Single read of word 4
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0010;
        bus.req_we    = 4'd0;
        step();
        idle_req();
        @(negedge clk);
        chk("rd_sram_ena",   bus.sram_ena,   32'd1);
        chk("rd_sram_addra", bus.sram_addra, 32'h00004);
        repeat (5) @(negedge clk);
        chk("rd_resp_valid", bus.resp_valid, 32'd1);
        chk("rd_resp_write", bus.resp_write, 32'd0);
        chk("rd_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
        step();

        // Byte write
        bus.req_valid = 1'b1;
        bus.req_we    = 4'b0010;
        bus.req_addr  = 32'h0000_0008;
        bus.req_wdata = 32'h1234_5678;
        step();
        idle_req();
        @(negedge clk);
        chk("wr_sram_ena",   bus.sram_ena,   32'd1);
        chk("wr_sram_wea",   bus.sram_wea,   32'h2);
        chk("wr_sram_addra", bus.sram_addra, 32'h00002);
        chk("wr_sram_dina",  bus.sram_dina,  32'h12345678);
        @(negedge clk);
        chk("wr_sram_ena_one_cycle", bus.sram_ena, 32'd0);
        chk("wr_sram_wea_cleared",   bus.sram_wea, 32'd0);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.resp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("wr_resp_seen",  ok, 32'd1);
        chk("wr_resp_write", bus.resp_write, 32'd1);
        chk("wr_resp_rdata", bus.resp_rdata, 32'd0);
        step();

        // Streaming: 8 reads, consumer always ready
        e0 = ena_cnt; p0 = pop_cnt;
        rr_low_seen = 1'b0; bad_gaps = 0; prev_ena = -1; gap_track = 1'b1;
        offer_reads(8, 32'h0000_0100, 50, acc);
        gap_track = 1'b0;
        chk("st_accepted",   acc, 32'd8);
        chk("st_ena_pulses", ena_cnt - e0, 32'd8);
        chk("st_bad_gaps",   bad_gaps, 32'd0);
        chk("st_rr_dropped", rr_low_seen, 32'd1);
        chk("st_responses",  pop_cnt - p0, 32'd8);

        // Backpressure: 6 reads with consumer stalled
        bus.resp_ready = 1'b0;
        e0 = ena_cnt; p0 = pop_cnt;
        offer_reads(6, 32'h0000_0200, 30, acc);
        chk("bp_accepted",   acc, 32'd6);
        chk("bp_ena_pulses", ena_cnt - e0, 32'd4);
        chk("bp_no_pops",    pop_cnt - p0, 32'd0);
        chk("bp_resp_valid", bus.resp_valid, 32'd1);
        e1 = ena_cnt; p1 = pop_cnt;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        repeat (4) step();
        chk("bp_one_pop",   pop_cnt - p1, 32'd1);
        chk("bp_one_issue", ena_cnt - e1, 32'd1);
        // Re-enabling now lines a pop up with the stage-4 push of that issue.
        bus.resp_ready = 1'b1;
        repeat (30) step();
        chk("bp_all_responses", pop_cnt - p0, 32'd6);
        chk("bp_all_issues",    ena_cnt - e0, 32'd6);

        // Reset with 2 reads in flight and 1 queued
        e0 = ena_cnt; acc = 0; ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 4'd0;
        bus.req_addr  = 32'h0000_0300;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) acc++;
            step();
            if (acc >= 3) bus.req_valid = 1'b0;
            else bus.req_addr = 32'h0000_0300 + 32'(acc * 4);
            if (ena_cnt - e0 == 2) begin ok = 1'b1; break; end
        end
        chk("rs_two_issued", ok, 32'd1);
        chk("rs_three_accepted", acc, 32'd3);
        reset = 1'b1;
        idle_req();
        @(negedge clk);
        chk("rs_lit_req_ready",  bus.req_ready,  32'd0);
        chk("rs_lit_resp_valid", bus.resp_valid, 32'd0);
        chk("rs_lit_sram_ena",   bus.sram_ena,   32'd0);
        chk("rs_lit_sram_addra", bus.sram_addra, 32'd0);
        step();
        step();
        reset = 1'b0;
        e1 = ena_cnt; p1 = pop_cnt;
        repeat (15) step();
        chk("rs_no_responses", pop_cnt - p1, 32'd0);
        chk("rs_no_issues",    ena_cnt - e1, 32'd0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0014;
        step();
        idle_req();
        @(negedge clk);
        chk("rs_new_ena",   bus.sram_ena,   32'd1);
        chk("rs_new_addra", bus.sram_addra, 32'h00005);
        repeat (5) @(negedge clk);
        chk("rs_new_resp_valid", bus.resp_valid, 32'd1);
        chk("rs_new_resp_rdata", bus.resp_rdata, 32'hC0DE0005);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
